sequential_comparator: RTL and testbench

SEQUENTIAL_COMPARATOR -- requirements
Module: sequential_comparator

---
 rtl/comparator_pkg.sv | 36 +++
 rtl/cmp_digit_slice.sv | 14 +
 rtl/sequential_comparator.sv | 131 +++++++++++++
 tb/tb_sequential_comparator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the digit-serial magnitude comparator:
// operation codes, FSM state encoding and the op-to-result mapping.
package comparator_pkg;

    localparam logic [2:0] EQUAL         = 3'd0;
    localparam logic [2:0] NOT_EQUAL     = 3'd1;
    localparam logic [2:0] LESS          = 3'd2;
    localparam logic [2:0] LESS_EQUAL    = 3'd3;
    localparam logic [2:0] GREATER       = 3'd4;
    localparam logic [2:0] GREATER_EQUAL = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reserved codes deliberately yield 0.
    function automatic logic map_result(
        input logic [2:0] op,
        input logic       rel_eq,
        input logic       rel_lt,
        input logic       rel_gt
    );
        case (op)
            EQUAL:         return rel_eq;
            NOT_EQUAL:     return ~rel_eq;
            LESS:          return rel_lt;
            LESS_EQUAL:    return rel_lt | rel_eq;
            GREATER:       return rel_gt;
            GREATER_EQUAL: return rel_gt | rel_eq;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmp_digit_slice.sv
// Combinational compare of one DIGIT-bit slice pair.
module cmp_digit_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             slice_eq,
    output logic             slice_lt
);

    assign slice_eq = (x == y);
    assign slice_lt = (x < y);

endmodule

// File: rtl/sequential_comparator.sv
// Digit-serial comparator: scans operands MSB slice first, one slice
// per cycle, and presents eq/lt/gt plus the selected relation.
module sequential_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DIGIT          = 4,
    parameter int SIGNED_COMPARE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] FLIP =
        (SIGNED_COMPARE != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("sequential_comparator: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             run_lt;
    logic             slice_eq;
    logic             slice_lt;
    logic             cur_decided;
    logic             cur_lt;
    logic             last;
    logic             fin_eq;
    logic             fin_lt;
    logic             fin_gt;

    cmp_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (a_q[WIDTH-1 -: DIGIT]),
        .y        (b_q[WIDTH-1 -: DIGIT]),
        .slice_eq (slice_eq),
        .slice_lt (slice_lt)
    );

    always_comb begin
        cur_decided = decided | ~slice_eq;
        cur_lt      = decided ? run_lt : slice_lt;
        last        = (cnt == LAST);
        fin_eq      = ~cur_decided;
        fin_lt      = cur_decided & cur_lt;
        fin_gt      = cur_decided & ~cur_lt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SCAN;
            end
            SCAN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand shift registers: the slice under test is always the top one.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q     <= a ^ FLIP;
            b_q     <= b ^ FLIP;
            op_q    <= op_sel;
            cnt     <= '0;
            decided <= 1'b0;
            run_lt  <= 1'b0;
        end else if (state == SCAN) begin
            a_q     <= a_q << DIGIT;
            b_q     <= b_q << DIGIT;
            decided <= cur_decided;
            run_lt  <= cur_lt;
            if (!last) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
        end else if (state == SCAN && last) begin
            result <= map_result(op_q, fin_eq, fin_lt, fin_gt);
            eq     <= fin_eq;
            lt     <= fin_lt;
            gt     <= fin_gt;
        end else if (out_valid && out_ready) begin
            result <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sequential_comparator.sv
// Directed bench: unsigned, signed and single-slice instances driven
// in lockstep from one stimulus stream.
module tb_sequential_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  op_sel = '0;

    logic u_in_ready, u_out_valid, u_result, u_eq, u_lt, u_gt;
    logic s_in_ready, s_out_valid, s_result, s_eq, s_lt, s_gt;
    logic w_in_ready, w_out_valid, w_result, w_eq, w_lt, w_gt;
    logic [3:0] u_vec, s_vec, w_vec;

    int checks = 0;
    int errors = 0;

    assign u_vec = {u_result, u_eq, u_lt, u_gt};
    assign s_vec = {s_result, s_eq, s_lt, s_gt};
    assign w_vec = {w_result, w_eq, w_lt, w_gt};

    always #5 clk = ~clk;

    sequential_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED_COMPARE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .a(a), .b(b), .op_sel(op_sel), .out_valid(u_out_valid),
        .out_ready(out_ready), .result(u_result), .eq(u_eq), .lt(u_lt), .gt(u_gt)
    );

    sequential_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED_COMPARE(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .op_sel(op_sel), .out_valid(s_out_valid),
        .out_ready(out_ready), .result(s_result), .eq(s_eq), .lt(s_lt), .gt(s_gt)
    );

    sequential_comparator #(.WIDTH(16), .DIGIT(16), .SIGNED_COMPARE(0)) w_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .op_sel(op_sel), .out_valid(w_out_valid),
        .out_ready(out_ready), .result(w_result), .eq(w_eq), .lt(w_lt), .gt(w_gt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // eu/es are {result,eq,lt,gt} for the unsigned and signed instances.
    task automatic txn(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [2:0] top, input logic [3:0] eu,
                       input logic [3:0] es, input int hold);
        @(negedge clk);
        a = ta; b = tb_v; op_sel = top; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = tb_v; b = ta; op_sel = ~top;
        chk({tag, "/busy"}, {u_in_ready, s_in_ready}, 16'h0);
        @(posedge clk);
        #1;
        chk({tag, "/w_lat"}, {w_out_valid, u_out_valid}, 16'h2);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "/early"}, {u_out_valid, s_out_valid}, 16'h0);
        @(posedge clk);
        #1;
        chk({tag, "/lat"}, {u_out_valid, s_out_valid, u_in_ready}, 16'h6);
        chk({tag, "/u"}, u_vec, eu);
        chk({tag, "/s"}, s_vec, es);
        chk({tag, "/w"}, w_vec, eu);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "/hold"}, {u_vec, u_out_valid, u_in_ready}, {10'h0, eu, 2'b10});
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, "/release"},
            {u_out_valid, u_in_ready, s_out_valid, s_in_ready, w_out_valid, w_in_ready},
            16'h15);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eq_res;
        logic       seen;
        eq_res = 8'b0010_1001;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_u", {u_in_ready, u_out_valid, u_vec}, 16'h20);
        chk("reset_s", {s_in_ready, s_out_valid, s_vec}, 16'h20);
        chk("reset_w", {w_in_ready, w_out_valid, w_vec}, 16'h20);
        @(negedge clk);
        rst_n = 1'b1;

        txn("lt_last_slice", 16'h1234, 16'h1235, 3'd2, 4'b1010, 4'b1010, 0);
        txn("gt_sign", 16'hFFFF, 16'h0001, 3'd4, 4'b1001, 4'b0010, 0);
        for (int op = 0; op < 8; op++) begin
            txn("eq_ops", 16'hA5A5, 16'hA5A5, 3'(op),
                {eq_res[op], 3'b100}, {eq_res[op], 3'b100}, 0);
        end
        txn("ge_hold", 16'h0010, 16'h0100, 3'd5, 4'b0010, 4'b0010, 10);
        txn("le_msb_wins", 16'h2000, 16'h1FFF, 3'd3, 4'b0001, 4'b0001, 0);
        txn("ne_sign", 16'h0000, 16'h8000, 3'd1, 4'b1010, 4'b1001, 0);
        txn("lt_capture", 16'h8000, 16'h7FFF, 3'd2, 4'b0001, 4'b1010, 0);

        // Abort in the second SCAN cycle.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F00; op_sel = 3'd2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_state",
            {u_in_ready, u_out_valid, s_in_ready, s_out_valid, w_in_ready, w_out_valid},
            16'h2A);
        chk("abort_w_flags", w_vec, 16'h0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | u_out_valid | s_out_valid | w_out_valid;
        end
        chk("abort_no_valid", {seen, u_in_ready}, 16'h1);
        txn("after_abort", 16'h00FF, 16'h0F00, 3'd2, 4'b1010, 4'b1010, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
